delay_calibrator: RTL and testbench

Measures the relative arrival skew of the coincidence-detector input channels and produces per-channel delay settings that align them. It drives the `Delays` configuration port of the channel delay stage. After a `Start` request it captures `2^NSAMP_LOG2` valid calibration events (one rising edge per channel), averages each channel's offset, and loads `Delays` so that every channel is padded to match the latest one.

---
 rtl/delay_calibrator.sv | 194 +++++++++++++++++++
 tb/tb_delay_calibrator.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_calibrator.sv
// delay_calibrator: measures the relative arrival skew of NCHAN calibration
// channels over 2^NSAMP_LOG2 complete events and loads per-channel Delays so
// every channel is padded to match the latest one.
// Optional feature macro: CALIB_TIMEOUT_EN (ARM gives up after TIMEOUT_CYCLES).
module delay_calibrator #(
    parameter int unsigned NCHAN          = 4,
    parameter int unsigned NBITS          = 4,
    parameter int unsigned NSAMP_LOG2     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [NCHAN-1:0] Channels,
    input  logic             Start,
    output logic [NBITS-1:0] Delays [NCHAN-1:0],
    output logic             Busy,
    output logic             Done,
    output logic [7:0]       Misses,
    output logic             Error
);

    localparam int unsigned    ACCW    = NBITS + NSAMP_LOG2;
    localparam int unsigned    EVW     = NSAMP_LOG2 + 1;
    // Half-LSB rounding term; integer division makes it vanish for NSAMP_LOG2 = 0.
    localparam logic [ACCW-1:0] RND     = ACCW'((2 ** NSAMP_LOG2) / 2);
    localparam logic [EVW-1:0]  LAST_EV = EVW'((2 ** NSAMP_LOG2) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WINDOW,
        S_AVG,
        S_ALIGN
    } state_t;

    state_t           state_q, state_d;
    logic [NCHAN-1:0] prev_q;
    logic [NCHAN-1:0] seen_q, seen_d;
    logic [NCHAN-1:0] rise, fresh;
    logic [NBITS-1:0] wcnt_q, wcnt_d;
    logic [NBITS-1:0] off_q [NCHAN-1:0];
    logic [NBITS-1:0] off_d [NCHAN-1:0];
    logic [ACCW-1:0]  acc_q [NCHAN-1:0];
    logic [ACCW-1:0]  acc_d [NCHAN-1:0];
    logic [NBITS-1:0] avg_q [NCHAN-1:0];
    logic [NBITS-1:0] avg_d [NCHAN-1:0];
    logic [NBITS-1:0] dly_q [NCHAN-1:0];
    logic [NBITS-1:0] dly_d [NCHAN-1:0];
    logic [EVW-1:0]   evcnt_q, evcnt_d;
    logic [7:0]       misses_q, misses_d;
    logic             done_q, done_d;
    logic [NBITS-1:0] peak;
    logic             error_q, error_d;

`ifdef CALIB_TIMEOUT_EN
    localparam int unsigned  TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
`endif

    assign rise   = Channels & ~prev_q;
    assign Delays = dly_q;
    assign Busy   = (state_q != S_IDLE);
    assign Done   = done_q;
    assign Misses = misses_q;
    assign Error  = error_q;

    // Next-state and datapath updates for the calibration sequence
    always_comb begin
        state_d  = state_q;
        seen_d   = seen_q;
        wcnt_d   = wcnt_q;
        off_d    = off_q;
        acc_d    = acc_q;
        avg_d    = avg_q;
        dly_d    = dly_q;
        evcnt_d  = evcnt_q;
        misses_d = misses_q;
        done_d   = 1'b0;
        error_d  = error_q;
        fresh    = '0;
        peak     = '0;
`ifdef CALIB_TIMEOUT_EN
        tcnt_d   = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    acc_d    = '{default: '0};
                    evcnt_d  = '0;
                    misses_d = '0;
                    error_d  = 1'b0;
                    state_d  = S_ARM;
                end
            end
            S_ARM: begin
                if (|rise) begin
                    seen_d  = rise;
                    off_d   = '{default: '0};
                    wcnt_d  = NBITS'(1);
                    state_d = S_WINDOW;
                end
`ifdef CALIB_TIMEOUT_EN
                else if (tcnt_q == TO_LAST) begin
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
`endif
            end
            S_WINDOW: begin
                fresh  = rise & ~seen_q;
                seen_d = seen_q | fresh;
                for (int unsigned i = 0; i < NCHAN; i++) begin
                    if (fresh[i]) off_d[i] = wcnt_q;
                end
                wcnt_d = wcnt_q + NBITS'(1);
                // Last window cycle: edges arriving now still count, so use off_d.
                if (wcnt_q == '1) begin
                    if (&(seen_q | fresh)) begin
                        for (int unsigned i = 0; i < NCHAN; i++) begin
                            acc_d[i] = acc_q[i] + ACCW'(off_d[i]);
                        end
                        evcnt_d = evcnt_q + EVW'(1);
                        state_d = (evcnt_q == LAST_EV) ? S_AVG : S_ARM;
                    end else begin
                        if (misses_q != '1) misses_d = misses_q + 8'd1;
                        state_d = S_ARM;
                    end
                end
            end
            S_AVG: begin
                for (int unsigned i = 0; i < NCHAN; i++) begin
                    avg_d[i] = NBITS'((acc_q[i] + RND) >> NSAMP_LOG2);
                end
                state_d = S_ALIGN;
            end
            S_ALIGN: begin
                for (int unsigned i = 0; i < NCHAN; i++) begin
                    if (avg_q[i] > peak) peak = avg_q[i];
                end
                for (int unsigned i = 0; i < NCHAN; i++) begin
                    dly_d[i] = peak - avg_q[i];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifndef CALIB_TIMEOUT_EN
        error_d = 1'b0;
`endif
    end

    // State and datapath registers, cleared by asynchronous reset
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            prev_q   <= '0;
            seen_q   <= '0;
            wcnt_q   <= '0;
            off_q    <= '{default: '0};
            acc_q    <= '{default: '0};
            avg_q    <= '{default: '0};
            dly_q    <= '{default: '0};
            evcnt_q  <= '0;
            misses_q <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
`ifdef CALIB_TIMEOUT_EN
            tcnt_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            prev_q   <= Channels;
            seen_q   <= seen_d;
            wcnt_q   <= wcnt_d;
            off_q    <= off_d;
            acc_q    <= acc_d;
            avg_q    <= avg_d;
            dly_q    <= dly_d;
            evcnt_q  <= evcnt_d;
            misses_q <= misses_d;
            done_q   <= done_d;
            error_q  <= error_d;
`ifdef CALIB_TIMEOUT_EN
            tcnt_q   <= tcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_delay_calibrator.sv
// Self-checking bench for delay_calibrator: an event-level reference model
// (offsets per event, sums, rounded averages) predicts Busy/Done/Misses/Error/
// Delays on every cycle, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_delay_calibrator;

    logic       Clk      = 1'b0;
    logic       Rst_n    = 1'b0;
    logic       Start    = 1'b0;
    logic [3:0] Channels = '0;
    logic [3:0] Delays [3:0];
    logic       Busy, Done, Error;
    logic [7:0] Misses;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Expected outputs, owned by the stimulus process
    int exp_busy   = 0;
    int exp_done   = 0;
    int exp_error  = 0;
    int exp_misses = 0;
    int exp_dly [4] = '{default: 0};

    // Event-level model state
    int m_sum [4] = '{default: 0};
    int m_cnt     = 0;
    bit cal_done  = 1'b0;

    // Current event description: offset -1 means the channel never rises
    int ev_off [4] = '{default: 0};
    int ev_dup_ch  = -1;
    int ev_dup_c   = -1;
    int ev_start_c = -1;
    int ev_gap     = 1;

    delay_calibrator #(
        .NCHAN(4),
        .NBITS(4),
        .NSAMP_LOG2(2),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .Channels(Channels),
        .Start(Start),
        .Delays(Delays),
        .Busy(Busy),
        .Done(Done),
        .Misses(Misses),
        .Error(Error)
    );

    always #5 Clk = ~Clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge Clk) begin
        if (cmp_en) begin
            check("busy", int'(Busy), exp_busy);
            check("done", int'(Done), exp_done);
            check("error", int'(Error), exp_error);
            check("misses", int'(Misses), exp_misses);
            for (int i = 0; i < 4; i++)
                check($sformatf("delay%0d", i), int'(Delays[i]), exp_dly[i]);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic lit_delays(input string tag, input int d0, input int d1,
                              input int d2, input int d3);
        int d [4];
        d = '{d0, d1, d2, d3};
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_delay%0d", tag, i), int'(Delays[i]), d[i]);
    endtask

    task automatic set_ev(input int o0, input int o1, input int o2, input int o3);
        ev_off     = '{o0, o1, o2, o3};
        ev_dup_ch  = -1;
        ev_dup_c   = -1;
        ev_start_c = -1;
        ev_gap     = 1;
    endtask

    task automatic begin_cal();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        m_sum      = '{default: 0};
        m_cnt      = 0;
        cal_done   = 1'b0;
        exp_misses = 0;
        exp_error  = 0;
        exp_busy   = 1;
    endtask

    task automatic apply_reset();
        Rst_n      = 1'b0;
        Channels   = '0;
        Start      = 1'b0;
        exp_busy   = 0;
        exp_done   = 0;
        exp_error  = 0;
        exp_misses = 0;
        exp_dly    = '{default: 0};
        m_sum      = '{default: 0};
        m_cnt      = 0;
    endtask

    // Drive one event window: the first pulse is window offset 0; then update
    // the model at the window end and, after the last needed event, predict Done.
    task automatic run_event();
        logic [3:0] ch;
        bit         all_seen;
        int         av [4];
        int         mx;
        for (int c = 0; c < 16; c++) begin
            ch = '0;
            for (int i = 0; i < 4; i++)
                if (ev_off[i] == c) ch[i] = 1'b1;
            if (ev_dup_ch >= 0 && ev_dup_c == c) ch[ev_dup_ch] = 1'b1;
            Channels = ch;
            Start    = (ev_start_c == c);
            tick();
        end
        Channels = '0;
        Start    = 1'b0;
        all_seen = 1'b1;
        for (int i = 0; i < 4; i++)
            if (ev_off[i] < 0 || ev_off[i] > 15) all_seen = 1'b0;
        if (all_seen) begin
            for (int i = 0; i < 4; i++) m_sum[i] += ev_off[i];
            m_cnt++;
        end else if (exp_misses < 255) begin
            exp_misses++;
        end
        if (all_seen && m_cnt == 4) begin
            mx = 0;
            for (int i = 0; i < 4; i++) begin
                av[i] = (m_sum[i] + 2) / 4;
                if (av[i] > mx) mx = av[i];
            end
            tick();
            tick();
            exp_done = 1;
            exp_busy = 0;
            for (int i = 0; i < 4; i++) exp_dly[i] = mx - av[i];
            tick();
            exp_done = 0;
            cal_done = 1'b1;
        end
        repeat (ev_gap) tick();
    endtask

    task automatic rand_event(input bit allow_miss);
        int z, d;
        for (int i = 0; i < 4; i++) ev_off[i] = int'($urandom_range(0, 15));
        z = int'($urandom_range(0, 3));
        ev_off[z] = 0;
        if (allow_miss && $urandom_range(0, 4) == 0)
            ev_off[(z + 1 + int'($urandom_range(0, 2))) % 4] = -1;
        ev_dup_ch = -1;
        ev_dup_c  = -1;
        if ($urandom_range(0, 2) == 0) begin
            d = int'($urandom_range(0, 3));
            if (ev_off[d] >= 0 && ev_off[d] <= 13) begin
                ev_dup_ch = d;
                ev_dup_c  = int'($urandom_range(ev_off[d] + 2, 15));
            end
        end
        ev_start_c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
        ev_gap     = int'($urandom_range(1, 3));
    endtask

    task automatic static_cal_events();
        repeat (4) begin
            set_ev(0, 3, 5, 1);
            run_event();
        end
    endtask

    initial begin
        // Reset state
        tick();
        cmp_en = 1'b1;
        tick();
        check("rst_busy", int'(Busy), 0);
        check("rst_done", int'(Done), 0);
        check("rst_misses", int'(Misses), 0);
        lit_delays("rst", 0, 0, 0, 0);
        Rst_n = 1'b1;
        tick();

        // Static skew
        begin_cal();
        static_cal_events();
        lit_delays("static", 5, 2, 0, 4);
        check("static_misses", int'(Misses), 0);

        // Averaging with round-half-up: ch1 sum 12 -> avg 3
        begin_cal();
        set_ev(0, 2, 0, 0); run_event();
        set_ev(0, 3, 0, 0); run_event();
        set_ev(0, 3, 0, 0); run_event();
        set_ev(0, 4, 0, 0); run_event();
        lit_delays("avg", 3, 0, 3, 3);

        // Missing channel in event 2
        begin_cal();
        for (int k = 0; k < 5; k++) begin
            set_ev(0, 3, 5, (k == 1) ? -1 : 1);
            run_event();
        end
        lit_delays("miss", 5, 2, 0, 4);
        check("miss_misses", int'(Misses), 1);

        // Window edge: offset 15 still counts
        begin_cal();
        repeat (4) begin
            set_ev(0, 0, 15, 0);
            run_event();
        end
        lit_delays("edge15", 15, 15, 0, 15);

        // Offset 16: ch2 lands the cycle after the window, starting a lone event
        begin_cal();
        set_ev(0, 0, -1, 0);
        ev_gap = 0;
        run_event();
        set_ev(-1, -1, 0, -1);
        run_event();
        check("off16_misses", int'(Misses), 2);
        static_cal_events();
        lit_delays("off16", 5, 2, 0, 4);

        // Start pulsed mid-window is ignored
        begin_cal();
        repeat (4) begin
            set_ev(0, 3, 5, 1);
            ev_start_c = 7;
            run_event();
        end
        lit_delays("midstart", 5, 2, 0, 4);

        // Reset mid-window clears outputs immediately
        begin_cal();
        set_ev(0, 2, 4, 6);
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < 4; i++) Channels[i] = (ev_off[i] == c);
            tick();
        end
        apply_reset();
        #1;
        check("rstwin_busy", int'(Busy), 0);
        lit_delays("rstwin", 0, 0, 0, 0);
        tick();
        Rst_n = 1'b1;
        tick();

        // Randomized calibrations
        for (int r = 0; r < 8; r++) begin
            begin_cal();
            for (int n = 0; n < 30 && !cal_done; n++) begin
                rand_event(n < 8);
                run_event();
            end
        end

        // Misses saturate at 255
        begin_cal();
        repeat (260) begin
            set_ev(0, -1, -1, -1);
            run_event();
        end
        check("sat_misses", int'(Misses), 255);
        static_cal_events();
        check("sat_misses_hold", int'(Misses), 255);
        lit_delays("sat", 5, 2, 0, 4);

`ifdef CALIB_TIMEOUT_EN
        // Timeout 100 cycles after ARM entry, Delays unchanged
        begin_cal();
        repeat (99) tick();
        tick();
        exp_done  = 1;
        exp_busy  = 0;
        exp_error = 1;
        check("to_error", int'(Error), 1);
        check("to_done", int'(Done), 1);
        tick();
        exp_done = 0;
        repeat (5) tick();
        check("to_error_hold", int'(Error), 1);
        lit_delays("to", 5, 2, 0, 4);
        begin_cal();
        check("to_error_clr", int'(Error), 0);
        static_cal_events();
`else
        // No timeout: ARM waits indefinitely
        begin_cal();
        repeat (200) tick();
        check("noto_busy", int'(Busy), 1);
        check("noto_error", int'(Error), 0);
        apply_reset();
        tick();
        Rst_n = 1'b1;
        tick();
`endif

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
